// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, endianness codes, output-state encoding, index-width helper
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  localparam int ENDIAN_LITTLE = 0;
  localparam int ENDIAN_BIG = 1;
  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_idle_timer.sv
// uart_idle_timer: idle counter with clear/enable and a terminal-count flag
// Ports: clk, rst (async high), clr_i (restart count), en_i (count while high), tc_o (count == CYCLES-1 while enabled)
module uart_idle_timer #(
  parameter int CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tc_o = en_i && (cnt_q == CW'(CYCLES - 1));
  always_comb cnt_d = (clr_i || !en_i || tc_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx_word_asm.sv
// uart_rx_word_asm: assembles BYTES_PER_WORD uart_rx bytes into a double-buffered word with valid/ready output
// Ports: clk, rst (async high), rx_done/rx_byte (byte strobe), flush (drop partial word),
//   word_data/word_valid/word_ready (output handshake), byte_idx (bytes held), overrun/timeout (1-cycle pulses)
// Optional: define UART_RX_WORD_ASM_TIMEOUT_EN to discard partial words after TIMEOUT_CYCLES idle cycles
module uart_rx_word_asm
  import uart_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int BIG_ENDIAN = ENDIAN_LITTLE,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rx_done,
  input  logic [UART_BYTE_W-1:0]                rx_byte,
  input  logic                                  flush,
  output logic [UART_BYTE_W*BYTES_PER_WORD-1:0] word_data,
  output logic                                  word_valid,
  input  logic                                  word_ready,
  output logic [idx_w(BYTES_PER_WORD)-1:0]      byte_idx,
  output logic                                  overrun,
  output logic                                  timeout
);
  localparam int W = UART_BYTE_W * BYTES_PER_WORD;
  localparam int IW = idx_w(BYTES_PER_WORD);
  localparam int LAST = BYTES_PER_WORD - 1;
  logic [IW-1:0] idx_q, idx_d, idx_cur;
  logic [W-1:0] asm_q, asm_d, asm_cur, asm_fill, word_q;
  out_state_e state_q;
  logic overrun_q, timeout_q, tmo, take, done;
  int slot;
`ifdef UART_RX_WORD_ASM_TIMEOUT_EN
  uart_idle_timer #(.CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk  (clk),
    .rst  (rst),
    .clr_i(rx_done || flush),
    .en_i (idx_q != '0),
    .tc_o (tmo)
  );
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  // A timeout discards the partial word in the same cycle, so a coincident byte starts a fresh word.
  always_comb begin
    idx_cur = tmo ? '0 : idx_q;
    asm_cur = tmo ? '0 : asm_q;
    slot = (BIG_ENDIAN == ENDIAN_BIG) ? LAST - int'(idx_cur) : int'(idx_cur);
    asm_fill = asm_cur;
    for (int k = 0; k < BYTES_PER_WORD; k++)
      if (k == slot) asm_fill[k*UART_BYTE_W +: UART_BYTE_W] = rx_byte;
    take = rx_done && !flush;
    done = take && (int'(idx_cur) == LAST);
    idx_d = (flush || done) ? '0 : take ? idx_cur + 1'b1 : idx_cur;
    asm_d = (flush || done) ? '0 : take ? asm_fill : asm_cur;
  end
  // Completion loads the output reg if it is empty or being drained this cycle; otherwise the new word is dropped.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= OUT_EMPTY;
      word_q <= '0;
      idx_q <= '0;
      asm_q <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
      timeout_q <= tmo && !flush;
      overrun_q <= done && (state_q == OUT_FULL) && !word_ready;
      if (done && (state_q == OUT_EMPTY || word_ready)) begin
        word_q <= asm_fill;
        state_q <= OUT_FULL;
      end else if (state_q == OUT_FULL && word_ready) begin
        state_q <= OUT_EMPTY;
      end
    end
  assign word_data = word_q;
  assign word_valid = (state_q == OUT_FULL);
  assign byte_idx = idx_q;
  assign overrun = overrun_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_uart_rx_word_asm.sv
// tb_uart_rx_word_asm: scoreboard bench driving little- and big-endian instances with the same byte stream
module tb_uart_rx_word_asm;
  logic clk = 1'b0, rst = 1'b1, rx_done = 1'b0, flush = 1'b0, word_ready = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [31:0] wd_l, wd_b;
  logic wv_l, wv_b, ov_l, ov_b, to_l, to_b;
  logic [1:0] bi_l, bi_b;
  int n_chk = 0, n_fail = 0, ov_cnt_l = 0, ov_cnt_b = 0;
  logic [31:0] q_l[$], q_b[$];
  always #5 clk = ~clk;
  uart_rx_word_asm #(.BYTES_PER_WORD(4), .BIG_ENDIAN(0), .TIMEOUT_CYCLES(50)) dut_l (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_byte(rx_byte), .flush(flush),
    .word_data(wd_l), .word_valid(wv_l), .word_ready(word_ready), .byte_idx(bi_l),
    .overrun(ov_l), .timeout(to_l));
  uart_rx_word_asm #(.BYTES_PER_WORD(4), .BIG_ENDIAN(1), .TIMEOUT_CYCLES(50)) dut_b (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_byte(rx_byte), .flush(flush),
    .word_data(wd_b), .word_valid(wv_b), .word_ready(word_ready), .byte_idx(bi_b),
    .overrun(ov_b), .timeout(to_b));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1 rx_done = 1'b0;
  endtask
  task automatic push(input logic [31:0] l, input logic [31:0] b);
    q_l.push_back(l);
    q_b.push_back(b);
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (ov_l) ov_cnt_l++;
      if (ov_b) ov_cnt_b++;
      if (wv_l && word_ready) begin
        if (q_l.size() == 0) check("l_unexpected_word", wd_l, 32'hxxxxxxxx);
        else check("l_word", wd_l, q_l.pop_front());
      end
      if (wv_b && word_ready) begin
        if (q_b.size() == 0) check("b_unexpected_word", wd_b, 32'hxxxxxxxx);
        else check("b_word", wd_b, q_b.pop_front());
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick(2);
    check("rst_valid", wv_l, 0);
    check("rst_data_l", wd_l, 0);
    check("rst_data_b", wd_b, 0);
    check("rst_idx", bi_l, 0);
    check("rst_overrun", ov_l, 0);
    check("rst_timeout", to_l, 0);
    rst = 1'b0;
    tick(1);
    word_ready = 1'b1;
    push(32'h44332211, 32'h11223344);
    send(8'h11);
    send(8'h22);
    check("idx_after_2", bi_l, 2);
    send(8'h33);
    send(8'h44);
    check("valid_latency1", wv_l, 1);
    check("word1_l", wd_l, 32'h44332211);
    check("word1_b", wd_b, 32'h11223344);
    check("idx_wrap", bi_l, 0);
    tick(1);
    check("valid_one_cycle", wv_l, 0);
    word_ready = 1'b0;
    push(32'h04030201, 32'h01020304);
    for (int i = 1; i <= 8; i++) send(8'(i));
    check("ovr_pulse", ov_l, 1);
    check("ovr_hold_l", wd_l, 32'h04030201);
    check("ovr_hold_b", wd_b, 32'h01020304);
    check("ovr_valid", wv_l, 1);
    check("ovr_idx", bi_l, 0);
    tick(1);
    check("ovr_one_cycle", ov_l, 0);
    check("ovr_count_l", ov_cnt_l, 1);
    check("ovr_count_b", ov_cnt_b, 1);
    word_ready = 1'b1;
    tick(1);
    check("accept_drop", wv_l, 0);
    send(8'hAA);
    send(8'hBB);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush_idx", bi_l, 0);
    rx_byte = 8'hCC;
    rx_done = 1'b1;
    flush = 1'b1;
    tick(1);
    rx_done = 1'b0;
    flush = 1'b0;
    check("flush_wins", bi_l, 0);
    push(32'h04030201, 32'h01020304);
    for (int i = 1; i <= 4; i++) send(8'(i));
    tick(2);
    check("flush_no_ovr", ov_cnt_l, 1);
    word_ready = 1'b0;
    push(32'h04030201, 32'h01020304);
    push(32'h08070605, 32'h05060708);
    for (int i = 1; i <= 7; i++) send(8'(i));
    check("held_valid", wv_l, 1);
    check("held_data", wd_l, 32'h04030201);
    rx_byte = 8'h08;
    rx_done = 1'b1;
    word_ready = 1'b1;
    tick(1);
    rx_done = 1'b0;
    check("coinc_valid", wv_l, 1);
    check("coinc_data_l", wd_l, 32'h08070605);
    check("coinc_data_b", wd_b, 32'h05060708);
    tick(1);
    check("coinc_drain", wv_l, 0);
    check("coinc_no_ovr", ov_cnt_l, 1);
`ifdef UART_RX_WORD_ASM_TIMEOUT_EN
    begin
      int hit;
      hit = 0;
      send(8'hAA);
      check("tmo_idx_before", bi_l, 1);
      for (int i = 1; i <= 100; i++) begin
        tick(1);
        if (to_l) begin
          hit = i;
          break;
        end
      end
      check("tmo_latency", hit, 50);
      check("tmo_idx_after", bi_l, 0);
      tick(1);
      check("tmo_one_cycle", to_l, 0);
      push(32'h04030201, 32'h01020304);
      for (int i = 1; i <= 4; i++) send(8'(i));
      tick(2);
    end
`endif
    word_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(8'(i));
    check("pre_rst_valid", wv_l, 1);
    check("pre_rst_idx", bi_l, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", wv_l, 0);
    check("mid_rst_data_l", wd_l, 0);
    check("mid_rst_data_b", wd_b, 0);
    check("mid_rst_idx", bi_l, 0);
    check("mid_rst_overrun", ov_l, 0);
    check("mid_rst_timeout", to_l, 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    check("post_rst_valid", wv_l, 0);
    check("q_l_empty", q_l.size(), 0);
    check("q_b_empty", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
